spi_sclk_sequencer: RTL

//  Registered, glitch-free SPI frame sequencer for the ADS131A0X host interface.

---
 rtl/spi_sclk_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/spi_sclk_sequencer.sv
// ============================================================================
// Module  : spi_sclk_sequencer
// Brief   : Registered SPI frame sequencer. Generates CS/SCLK for one frame in
//           any CPOL/CPHA mode, with per-edge shift/sample strobes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_sclk_sequencer #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned FRAME_BITS = 24,
    parameter bit          CPOL       = 1'b0,
    parameter bit          CPHA       = 1'b1,
    parameter int unsigned CS_SETUP   = 2,
    parameter int unsigned CS_HOLD    = 2,
    parameter int unsigned CNT_W      = 5
) (
    input  logic             CLK_4_167,
    input  logic             RESET,
    input  logic             START,
    input  logic             ABORT,
    output logic             BUSY,
    output logic             DONE,
    output logic             SPI_CS,
    output logic             SPI_SCLK,
    output logic             SHIFT_EDGE,
    output logic             SAMPLE_EDGE,
    output logic [CNT_W-1:0] BIT_CNT
);

    localparam int unsigned PH_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
    localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned EDGE_W = $clog2(2 * FRAME_BITS + 1);

    localparam logic [PH_W-1:0]   SETUP_LAST = PH_W'(CS_SETUP - 1);
    localparam logic [PH_W-1:0]   HOLD_LAST  = PH_W'(CS_HOLD - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST  = EDGE_W'(2 * FRAME_BITS - 1);
    localparam logic [CNT_W-1:0]  FRAME_MAX  = CNT_W'(FRAME_BITS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_RUN   = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t             state_q,   state_d;
    logic [PH_W-1:0]    phase_q,   phase_d;
    logic [DIV_W-1:0]   div_q,     div_d;
    logic [EDGE_W-1:0]  edge_q,    edge_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               sclk_q,    sclk_d;
    logic               cs_q,      cs_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic               shift_q,   shift_d;
    logic               sample_q,  sample_d;
    logic               w_leading;
    logic               w_last;

    always_ff @(posedge CLK_4_167) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            div_q     <= '0;
            edge_q    <= '0;
            bit_cnt_q <= '0;
            sclk_q    <= CPOL;
            cs_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            shift_q   <= 1'b0;
            sample_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            div_q     <= div_d;
            edge_q    <= edge_d;
            bit_cnt_q <= bit_cnt_d;
            sclk_q    <= sclk_d;
            cs_q      <= cs_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            shift_q   <= shift_d;
            sample_q  <= sample_d;
        end
    end

    // Edge count before this toggle is even => this toggle is a leading edge.
    assign w_leading = ~edge_q[0];
    assign w_last    = (edge_q == EDGE_LAST);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        div_d     = div_q;
        edge_d    = edge_q;
        bit_cnt_d = bit_cnt_q;
        sclk_d    = sclk_q;
        cs_d      = cs_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        shift_d   = 1'b0;
        sample_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START && !ABORT) begin
                    state_d   = S_SETUP;
                    phase_d   = '0;
                    cs_d      = 1'b0;
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                    shift_d   = !CPHA && (CS_SETUP == 1);
                end
            end
            S_SETUP: begin
                if (phase_q == SETUP_LAST) begin
                    state_d = S_RUN;
                    div_d   = '0;
                    edge_d  = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                    // CPHA=0 presents bit 0 on the final setup cycle.
                    shift_d = !CPHA && ((phase_q + 1'b1) == SETUP_LAST);
                end
            end
            S_RUN: begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + 1'b1;
                    if (w_leading) begin
                        sample_d = !CPHA;
                        shift_d  = CPHA;
                    end else begin
                        sample_d = CPHA;
                        shift_d  = !CPHA && !w_last;
                    end
                    if (sample_d && (bit_cnt_q != FRAME_MAX)) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                    if (w_last) begin
                        state_d = S_HOLD;
                        phase_d = '0;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (phase_q == HOLD_LAST) begin
                    state_d = S_IDLE;
                    cs_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (ABORT && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            cs_d     = 1'b1;
            sclk_d   = CPOL;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            shift_d  = 1'b0;
            sample_d = 1'b0;
        end
    end

    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign SPI_CS      = cs_q;
    assign SPI_SCLK    = sclk_q;
    assign SHIFT_EDGE  = shift_q;
    assign SAMPLE_EDGE = sample_q;
    assign BIT_CNT     = bit_cnt_q;

endmodule

`default_nettype wire
